// File: rtl/sfx_pkg.sv
// sfx_sequencer shared types, note constants and effect table functions.
// Table functions are only evaluated at elaboration to build the ROM.
package sfx_pkg;

   typedef enum logic {
      IDLE,
      PLAY
   } state_t;

   localparam int SIL = 0;
   localparam int C3  = 262;
   localparam int D3  = 294;
   localparam int E3  = 330;
   localparam int F3  = 349;
   localparam int G3  = 392;
   localparam int A3  = 440;
   localparam int B3  = 494;
   localparam int C4  = 524;
   localparam int D4  = 588;
   localparam int E4  = 660;
   localparam int F4  = 698;
   localparam int G4  = 784;
   localparam int A4  = 880;

   localparam int SFX_MAX_LEN = 8;
   localparam int SFX_TBL_N   = 4;

   function automatic int sfx_len(input int id);
      int l;
      case (id)
         0:       l = 2;
         1:       l = 3;
         2:       l = 4;
         3:       l = SFX_MAX_LEN;
         default: l = 1;
      endcase
      return l;
   endfunction

   function automatic int sfx_freq_r(input int id, input int s);
      int f;
      f = SIL;
      case (id)
         0: case (s)
               0: f = C4;
               1: f = G4;
               default: f = SIL;
            endcase
         1: case (s)
               0: f = E4;
               1: f = A4;
               2: f = A4;
               default: f = SIL;
            endcase
         2: case (s)
               0: f = G4;
               1: f = E4;
               2: f = C4;
               default: f = SIL;
            endcase
         3: case (s)
               0: f = C4;
               2: f = C4;
               4: f = G3;
               5: f = G3;
               default: f = SIL;
            endcase
         default: f = SIL;
      endcase
      return f;
   endfunction

   // score opens with a right-only note; all other effects are mono
   function automatic int sfx_freq_l(input int id, input int s);
      int f;
      f = sfx_freq_r(id, s);
      if (id == 1 && s == 0) f = SIL;
      return f;
   endfunction

   function automatic int freq2div(input int clk_hz, input int f);
      int d;
      if (f == SIL) d = 1;
      else d = clk_hz / (2 * f) - 1;
      return d;
   endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// Trigger / mute / playback-status bundle between game logic and sequencer.
// master drives requests, slave is the sequencer.
interface sfx_sequencer_if #(
   parameter int NUM_SFX = 4,
   parameter int DIV_W   = 22
) ();

   localparam int IDW = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;

   logic [NUM_SFX-1:0] trig;
   logic               mute_l;
   logic               mute_r;
   logic               busy;
   logic [IDW-1:0]     active_id;
   logic [3:0]         step;
   logic [DIV_W-1:0]   note_div_left;
   logic [DIV_W-1:0]   note_div_right;
   logic               done;

   modport master (
      output trig, mute_l, mute_r,
      input  busy, active_id, step,
      input  note_div_left, note_div_right, done
   );

   modport slave (
      input  trig, mute_l, mute_r,
      output busy, active_id, step,
      output note_div_left, note_div_right, done
   );

endinterface

// File: rtl/sfx_rom.sv
// Combinational (effect, step) -> stereo divisor and effect length lookup.
// All entries are constants folded at elaboration.
module sfx_rom
   import sfx_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int DIV_W  = 22,
   parameter int IDW    = 2
) (
   input  logic [IDW-1:0]   active_id,
   input  logic [3:0]       step,
   output logic [DIV_W-1:0] div_l,
   output logic [DIV_W-1:0] div_r,
   output logic [3:0]       len
);

   logic [DIV_W-1:0] tbl_l [64];
   logic [DIV_W-1:0] tbl_r [64];
   logic [3:0]       tbl_len [SFX_TBL_N];
   logic [5:0]       idx;

   for (genvar i = 0; i < SFX_TBL_N; i++) begin : g_id
      assign tbl_len[i] = 4'(sfx_len(i));
      for (genvar s = 0; s < 16; s++) begin : g_st
         assign tbl_l[i*16+s] =
            DIV_W'(freq2div(CLK_HZ, sfx_freq_l(i, s)));
         assign tbl_r[i*16+s] =
            DIV_W'(freq2div(CLK_HZ, sfx_freq_r(i, s)));
      end
   end

   assign idx   = {2'(active_id), step};
   assign div_l = tbl_l[idx];
   assign div_r = tbl_r[idx];
   assign len   = tbl_len[idx[5:4]];

endmodule

// File: rtl/sfx_sequencer.sv
// Fixed-priority sound-effect sequencer with preemption and retrigger.
// Steps a per-effect stereo note table at BEAT_HZ and feeds note_gen.
module sfx_sequencer
   import sfx_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int BEAT_HZ = 8,
   parameter int NUM_SFX = 4,
   parameter int DIV_W   = 22
) (
   input logic          clk,
   input logic          rst,
   sfx_sequencer_if.slave bus
);

   localparam int IDW      = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
   localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
   localparam int BCW      = $clog2(BEAT_DIV);
   localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEAT_DIV - 1);

   state_t         state, state_n;
   logic [IDW-1:0] id_q, id_n;
   logic [3:0]     step_q, step_n;
   logic [BCW-1:0] bc_q, bc_n;
   logic           done_q, done_n;

   logic [IDW-1:0]   win;
   logic             any;
   logic [DIV_W-1:0] rom_l, rom_r;
   logic [3:0]       len;

   always_comb begin
      win = '0;
      for (int i = 0; i < NUM_SFX; i++)
         if (bus.trig[i]) win = IDW'(i);
   end

   assign any = |bus.trig;

   sfx_rom #(
      .CLK_HZ (CLK_HZ),
      .DIV_W  (DIV_W),
      .IDW    (IDW)
   ) u_rom (
      .active_id (id_q),
      .step      (step_q),
      .div_l     (rom_l),
      .div_r     (rom_r),
      .len       (len)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         id_q   <= '0;
         step_q <= '0;
         bc_q   <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         id_q   <= id_n;
         step_q <= step_n;
         bc_q   <= bc_n;
         done_q <= done_n;
      end
   end

   // a winner at or above the playing id outranks the end-of-effect check
   always_comb begin
      state_n = state;
      id_n    = id_q;
      step_n  = step_q;
      bc_n    = bc_q;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) begin
               state_n = PLAY;
               id_n    = win;
               step_n  = '0;
               bc_n    = '0;
            end
         end
         PLAY: begin
            if (any && win >= id_q) begin
               id_n   = win;
               step_n = '0;
               bc_n   = '0;
            end else if (bc_q == BEAT_LAST) begin
               bc_n = '0;
               if (step_q == len - 4'd1) begin
                  state_n = IDLE;
                  step_n  = '0;
                  done_n  = 1'b1;
               end else begin
                  step_n = step_q + 4'd1;
               end
            end else begin
               bc_n = bc_q + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.busy      = (state == PLAY);
   assign bus.active_id = id_q;
   assign bus.step      = step_q;
   assign bus.done      = done_q;

   assign bus.note_div_left =
      (!bus.busy || bus.mute_l) ? DIV_W'(1) : rom_l;
   assign bus.note_div_right =
      (!bus.busy || bus.mute_r) ? DIV_W'(1) : rom_r;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer: directed table, corner sequences
// and randomized triggers against an elapsed-time reference model.
module tb_sfx_sequencer;

   localparam int CLK_HZ  = 100_000_000;
   localparam int BEAT_HZ = 25_000_000;
   localparam int BD      = CLK_HZ / BEAT_HZ;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sfx_sequencer_if #(.NUM_SFX(4), .DIV_W(22)) tif ();

   sfx_sequencer #(
      .CLK_HZ  (CLK_HZ),
      .BEAT_HZ (BEAT_HZ),
      .NUM_SFX (4),
      .DIV_W   (22)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (tif.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   int f_l [4][8];
   int f_r [4][8];
   int lens [4];

   bit m_busy;
   bit m_done;
   int m_id;
   int m_t;

   typedef struct {
      logic [3:0] trig;
      logic       r;
      int         busy;
      int         id;
      int         step;
      int         dl;
      int         dr;
      int         done;
   } vec_t;

   vec_t vt [13];

   function automatic int exp_div(input int f);
      return (f == 0) ? 1 : CLK_HZ / (2 * f) - 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic [3:0] tr, input logic r);
      int w;
      if (r) begin
         m_busy = 0; m_done = 0; m_id = 0; m_t = 0;
      end else begin
         m_done = 0;
         w = -1;
         for (int i = 0; i < 4; i++) if (tr[i]) w = i;
         if (w >= 0 && (!m_busy || w >= m_id)) begin
            m_busy = 1; m_id = w; m_t = 0;
         end else if (m_busy) begin
            m_t++;
            if (m_t == lens[m_id] * BD) begin
               m_busy = 0; m_done = 1; m_t = 0;
            end
         end
      end
   endtask

   task automatic check_model();
      int el, er;
      el = 1; er = 1;
      if (m_busy) begin
         if (!tif.mute_l) el = exp_div(f_l[m_id][m_t / BD]);
         if (!tif.mute_r) er = exp_div(f_r[m_id][m_t / BD]);
         chk("m_step", int'(tif.step), m_t / BD);
      end
      chk("m_busy", int'(tif.busy), int'(m_busy));
      chk("m_done", int'(tif.done), int'(m_done));
      chk("m_id", int'(tif.active_id), m_id);
      chk("m_div_l", int'(tif.note_div_left), el);
      chk("m_div_r", int'(tif.note_div_right), er);
   endtask

   task automatic cyc(input logic [3:0] tr, input logic r, input bit cm);
      tif.trig = tr;
      rst      = r;
      @(posedge clk);
      model_step(tr, r);
      #1;
      if (cm) check_model();
   endtask

   task automatic run_until_done(input int bound, output int k);
      k = 1;
      do begin
         cyc(4'b0000, 1'b0, 1'b1);
         k++;
      end while (!tif.done && k < bound);
      if (!tif.done) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int k;
      f_r[0] = '{524, 784, 0, 0, 0, 0, 0, 0};
      f_r[1] = '{660, 880, 880, 0, 0, 0, 0, 0};
      f_r[2] = '{784, 660, 524, 0, 0, 0, 0, 0};
      f_r[3] = '{524, 0, 524, 0, 392, 392, 0, 0};
      f_l = f_r;
      f_l[1][0] = 0;
      lens = '{2, 3, 4, 8};

      vt[0]  = '{4'h0, 1'b1, 0, 0, 0, 1, 1, 0};
      vt[1]  = '{4'h0, 1'b1, 0, 0, 0, 1, 1, 0};
      vt[2]  = '{4'h0, 1'b0, 0, 0, 0, 1, 1, 0};
      vt[3]  = '{4'h1, 1'b0, 1, 0, 0, 95418, 95418, 0};
      vt[4]  = '{4'h0, 1'b0, 1, 0, 0, 95418, 95418, 0};
      vt[5]  = '{4'h0, 1'b0, 1, 0, 0, 95418, 95418, 0};
      vt[6]  = '{4'h0, 1'b0, 1, 0, 0, 95418, 95418, 0};
      vt[7]  = '{4'h0, 1'b0, 1, 0, 1, 63774, 63774, 0};
      vt[8]  = '{4'h0, 1'b0, 1, 0, 1, 63774, 63774, 0};
      vt[9]  = '{4'h0, 1'b0, 1, 0, 1, 63774, 63774, 0};
      vt[10] = '{4'h0, 1'b0, 1, 0, 1, 63774, 63774, 0};
      vt[11] = '{4'h0, 1'b0, 0, 0, -1, 1, 1, 1};
      vt[12] = '{4'h0, 1'b0, 0, 0, -1, 1, 1, 0};

      tif.trig   = '0;
      tif.mute_l = 1'b0;
      tif.mute_r = 1'b0;
      rst        = 1'b1;

      foreach (vt[i]) begin
         cyc(vt[i].trig, vt[i].r, 1'b0);
         chk("t_busy", int'(tif.busy), vt[i].busy);
         chk("t_id", int'(tif.active_id), vt[i].id);
         if (vt[i].step >= 0) chk("t_step", int'(tif.step), vt[i].step);
         chk("t_div_l", int'(tif.note_div_left), vt[i].dl);
         chk("t_div_r", int'(tif.note_div_right), vt[i].dr);
         chk("t_done", int'(tif.done), vt[i].done);
      end

      repeat (10) cyc(4'b0000, 1'b0, 1'b1);

      cyc(4'b0010, 1'b0, 1'b1);
      chk("score_l0", int'(tif.note_div_left), 1);
      chk("score_r0", int'(tif.note_div_right), 75756);
      run_until_done(40, k);
      chk("score_done_cyc", k, 13);

      cyc(4'b0001, 1'b0, 1'b1);
      cyc(4'b0000, 1'b0, 1'b1);
      cyc(4'b0100, 1'b0, 1'b1);
      chk("pre_id", int'(tif.active_id), 2);
      chk("pre_step", int'(tif.step), 0);
      run_until_done(40, k);
      chk("pre_done_cyc", k, 17);

      cyc(4'b0100, 1'b0, 1'b1);
      for (int i = 2; i <= 16; i++) begin
         cyc((i == 6) ? 4'b0001 : 4'b0000, 1'b0, 1'b1);
         if (i == 6) chk("ign_id", int'(tif.active_id), 2);
      end
      chk("fin_step", int'(tif.step), 3);
      cyc(4'b0100, 1'b0, 1'b1);
      chk("rt_busy", int'(tif.busy), 1);
      chk("rt_done", int'(tif.done), 0);
      chk("rt_step", int'(tif.step), 0);
      run_until_done(40, k);
      chk("rt_done_cyc", k, 17);

      tif.mute_l = 1'b1;
      cyc(4'b1000, 1'b0, 1'b1);
      for (int i = 2; i <= 14; i++) begin
         cyc(4'b0000, 1'b0, 1'b1);
         chk("mute_l", int'(tif.note_div_left), 1);
      end
      chk("over_step", int'(tif.step), 3);
      cyc(4'b0000, 1'b1, 1'b1);
      chk("rst_busy", int'(tif.busy), 0);
      chk("rst_id", int'(tif.active_id), 0);
      chk("rst_step", int'(tif.step), 0);
      chk("rst_done", int'(tif.done), 0);
      chk("rst_div_r", int'(tif.note_div_right), 1);
      cyc(4'b0000, 1'b0, 1'b1);
      chk("rst_nodone", int'(tif.done), 0);
      tif.mute_l = 1'b0;

      for (int i = 0; i < 2000; i++) begin
         logic [3:0] tr;
         tr = ($urandom_range(0, 14) == 0) ? 4'($urandom) : 4'b0000;
         if ($urandom_range(0, 30) == 0) tif.mute_l = 1'($urandom);
         if ($urandom_range(0, 30) == 0) tif.mute_r = 1'($urandom);
         cyc(tr, ($urandom_range(0, 400) == 0) ? 1'b1 : 1'b0, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Parametrised sound-effect sequencer for the game audio path. It accepts one-cycle trigger requests for up to `NUM_SFX` effects and arbitrates them by fixed priority, with preemption and retrigger. Each effect steps through a per-effect stereo note table at a fixed beat rate, and the block drives `note_div_left`/`note_div_right` directly into `note_gen`. It replaces the fixed two-effect `player_control` + `music_example` pair, adding effect length, priority and completion reporting.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BEAT_HZ`, 8: step rate. `BEAT_DIV = CLK_HZ/BEAT_HZ` cycles per step, and `BEAT_DIV` must be ≥ 2.
- `NUM_SFX`, 4: number of effects, range 1..4. Higher index means higher priority.
- `DIV_W`, 22: note divisor width.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `trig` in `NUM_SFX`: per-effect start request, sampled every cycle.
- `mute_l`, `mute_r` in 1: force the silence divisor on that channel. Sequencing continues while muted.
- `busy` out 1: an effect is playing.
- `active_id` out `max(1,$clog2(NUM_SFX))`: id of the playing effect. Holds the last value when idle.
- `step` out 4: current step index.
- `note_div_left`, `note_div_right` out `DIV_W`: divisor for `note_gen`. A value of 1 means silence.
- `done` out 1: one-cycle pulse when an effect completes naturally.

## Operation
- The FSM has two states, IDLE and PLAY.
- Winner: the highest-index set bit of `trig`.
- **IDLE:**
  - If `trig != 0`, go to PLAY with `active_id` = winner, `step` = 0 and `beat_cnt` = 0.
  - Otherwise stay in IDLE.
- **PLAY**, checked in this priority order:
  1. Winner id ≥ `active_id`: restart with the winner at step 0 and `beat_cnt` = 0.
     - This covers both preemption (winner > `active_id`) and retrigger (winner == `active_id`).
     - No `done` is pulsed for the interrupted effect.
  2. Lower-priority triggers are ignored and dropped. They are not queued.
  3. When `beat_cnt == BEAT_DIV-1`:
     - If `step == len(active_id)-1`, go to IDLE and pulse `done`.
     - Otherwise increment `step` and set `beat_cnt` to 0.
  4. Otherwise increment `beat_cnt`.
- Rule 1 has precedence over rule 3 on the same cycle, so a trigger on the final tick restarts playback and no `done` is pulsed.
- **Divisor:**
  - `note_div_x = 1` if IDLE, `mute_x` is set, or the table entry is silence.
  - Otherwise `note_div_x` = table divisor. The divisor for frequency f is `CLK_HZ/(2*f) - 1`, using integer division and computed at elaboration, never at runtime.
- **Effect tables** (L = R unless stated):
  - 0 jump: C4 524, G4 784. Length 2.
  - 1 score: E4 660, A4 880, A4 880. Length 3. Left plays silence on step 0.
  - 2 hit: G4, E4, C4, sil. Length 4.
  - 3 over: C4, sil, C4, sil, G3 392, G3, sil, sil. Length 8.
- `beat_cnt` width is `$clog2(BEAT_DIV)`. It never wraps past `BEAT_DIV-1`.

## Timing
- Reset values:
  - `busy`=0, `active_id`=0, `step`=0, `done`=0.
  - `note_div_left` = `note_div_right` = 1.
  - Internal `beat_cnt`=0, state IDLE.
  - A reset mid-effect aborts it silently, with no `done`.
- `trig` sampled high at edge t gives `busy`, `active_id` and `step`=0 valid after edge t+1. `note_div_*` becomes valid in the same cycle, as a combinational decode of registered state.
- Each step lasts exactly `BEAT_DIV` cycles, so an effect occupies `len*BEAT_DIV` cycles from the first busy cycle.
- `done` and the `busy` 1→0 transition occur in the same cycle, immediately after the final step's last cycle.
- Mute takes effect combinationally, in the same cycle.

## Structure
- Package `sfx_pkg` contains:
  - State enum.
  - Note frequency constants (C3..A4, SIL = 0).
  - `SFX_MAX_LEN = 8`.
  - Constant functions `sfx_len(id)`, `sfx_freq_l(id,step)`, `sfx_freq_r(id,step)`.
  - `freq2div(clk_hz,f)`, which returns 1 for SIL.
- One natural sub-module: `sfx_rom`, a combinational (`active_id`, `step`) → (`div_l`, `div_r`, `len`) lookup. It is parametrised by `CLK_HZ`/`DIV_W` and instantiated once.
- Arbitration, beat counter and FSM live in `sfx_sequencer`.

## Test plan
Bench parameters: `CLK_HZ`=100_000_000 and `BEAT_HZ`=25_000_000, so `BEAT_DIV`=4.
- Reset, then idle for 10 cycles: `busy`=0, `done`=0, both divs stay 1.
- Pulse `trig`=0001:
  - Cycles 1–4 show `step`=0 and div_R=95418.
  - Cycles 5–8 show `step`=1 and div_R=63774.
  - Cycle 9 shows `busy`=0, `done`=1 for exactly one cycle, and divs=1.
- Play score (`trig`=0010):
  - Step 0 shows L=1, R=75756.
  - Steps 1–2 show L=R=56817.
  - `done` is pulsed after 12 cycles.
- Start jump, then at cycle 3 pulse `trig`=0100:
  - Preemption occurs: `active_id`=2, `step`=0.
  - No `done` is pulsed for jump.
  - `done` pulses 16 cycles later.
- During hit, pulse `trig`=0001: it is ignored. Pulse `trig`=0100 on the final tick: hit restarts at step 0 and no `done` is pulsed.
- Play over with `mute_l`=1:
  - `note_div_left` is 1 throughout, while the right channel sequences normally.
  - Asserting `rst` mid-step 3 gives all reset values on the next cycle, with no `done`.
